// File: rtl/wb_burst_pkg.sv
// Shared types and constants for the Wishbone burst master.
//   state_t     : burst FSM states
//   WORD_STRIDE : byte-address increment between consecutive words
//   WE_ALL      : byte-enable pattern for a full-word write
//   req_t       : one bus request as held in the output register
package wb_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned WORD_STRIDE = 4;
    localparam logic [3:0]  WE_ALL      = 4'hF;

    localparam int REQ_ADDR_W = 11;
    localparam int REQ_DATA_W = 32;

    typedef struct packed {
        logic [3:0]            we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } req_t;

endpackage

// File: rtl/wb_burst_master_req_hold.sv
// Single-entry request holding register driving the Wishbone strobe.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   load_i       : capture req_i and raise stb_o (only when empty or accepted)
//   req_i        : request to capture
//   stall_i      : slave stall
//   stb_o        : request strobe
//   accept_o     : request taken by the slave this cycle (stb & !stall)
//   req_o        : held request; bit-stable while stalled
module wb_req_hold
    import wb_burst_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  req_t req_i,
    input  logic stall_i,
    output logic stb_o,
    output logic accept_o,
    output req_t req_o
);

    assign accept_o = stb_o & ~stall_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stb_o <= 1'b0;
            req_o <= '0;
        end else if (load_i) begin
            stb_o <= 1'b1;
            req_o <= req_i;
        end else if (accept_o) begin
            stb_o <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_burst_master.sv
// Command-driven Wishbone pipelined burst master for one RAM port.
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   cmd_valid_i/cmd_ready_o      : burst command handshake (ready only in IDLE)
//   cmd_write_i, cmd_addr_i,
//   cmd_len_i                    : direction, start byte address, word count
//   wr_valid_i/wr_ready_o/wr_data_i : write-data stream, one word per request
//   rd_valid_o/rd_data_o         : read-data stream in request order
//   done_o                       : one-cycle pulse at burst completion
//   err_o                        : sticky, ack seen with nothing outstanding
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o : Wishbone request
//   wb_stall_i, wb_ack_i, wb_data_i                   : Wishbone response
module wb_burst_master
    import wb_burst_pkg::*;
#(
    parameter int ADDR_W  = REQ_ADDR_W,
    parameter int DATA_W  = REQ_DATA_W,
    parameter int LEN_W   = 9,
    parameter int MAX_OUT = 4
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              done_o,
    output logic              err_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic [3:0]        wb_we_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic              wb_stall_i,
    input  logic              wb_ack_i,
    input  logic [DATA_W-1:0] wb_data_i
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic              write_q;
    logic [OUT_W-1:0]  out_q, out_nxt;
    logic              cmd_acc, ack_cnt, accept, load, room, stb;
    req_t              load_req, hold_req;

    assign cmd_ready_o = (state == IDLE);
    assign cmd_acc     = cmd_valid_i & cmd_ready_o;
    assign wb_cyc_o    = (state == ISSUE) | (state == DRAIN);
    assign done_o      = (state == DONE);

    // An ack only counts against a request actually in flight; anything else
    // is a protocol error (inside a burst) or noise (outside one).
    assign ack_cnt = wb_cyc_o & wb_ack_i & (out_q != '0);

    always_comb begin
        out_nxt = out_q;
        if (accept && !ack_cnt) begin
            out_nxt = out_q + OUT_W'(1);
        end else if (!accept && ack_cnt) begin
            out_nxt = out_q - OUT_W'(1);
        end
    end

    // The loaded request adds one in-flight slot once accepted; acks in the
    // meantime can only lower the count, so checking against out_nxt suffices.
    assign room = (out_nxt < OUT_W'(MAX_OUT));
    assign load = (state == ISSUE) & (~stb | accept) & (issued_q < len_q)
                & room & (~write_q | wr_valid_i);
    assign wr_ready_o = load & write_q;

    always_comb begin
        load_req      = '0;
        load_req.we   = write_q ? WE_ALL : 4'h0;
        load_req.addr = addr_q;
        load_req.data = write_q ? wr_data_i : '0;
    end

    wb_req_hold u_hold (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load),
        .req_i    (load_req),
        .stall_i  (wb_stall_i),
        .stb_o    (stb),
        .accept_o (accept),
        .req_o    (hold_req)
    );

    assign wb_stb_o  = stb;
    assign wb_we_o   = hold_req.we;
    assign wb_addr_o = hold_req.addr;
    assign wb_data_o = hold_req.data;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cmd_acc) state_nxt = (cmd_len_i == '0) ? DONE : ISSUE;
            // issued_q == len_q means the held request is the final one
            ISSUE:   if (accept && (issued_q == len_q)) state_nxt = DRAIN;
            DRAIN:   if (out_nxt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            write_q  <= 1'b0;
            out_q    <= '0;
            err_o    <= 1'b0;
        end else begin
            state <= state_nxt;
            out_q <= out_nxt;
            if (cmd_acc) begin
                addr_q   <= cmd_addr_i & ~ADDR_W'(3);
                len_q    <= cmd_len_i;
                write_q  <= cmd_write_i;
                issued_q <= '0;
                err_o    <= 1'b0;
            end else begin
                if (load) begin
                    addr_q   <= addr_q + ADDR_W'(WORD_STRIDE);
                    issued_q <= issued_q + LEN_W'(1);
                end
                if (wb_cyc_o && wb_ack_i && (out_q == '0)) begin
                    err_o <= 1'b1;
                end
            end
        end
    end

    // read return stage: one cycle after the counted ack
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= ack_cnt & ~write_q;
            if (ack_cnt && !write_q) begin
                rd_data_o <= wb_data_i;
            end
        end
    end

endmodule
